// File: rtl/gen_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// gen_sched_ctrl_if
// Start/done handshake between the generation scheduler and the Round and copy
// engines. Every signal is a one-cycle pulse that is synchronous to clk_vga.
//
//   round_start_o : scheduler -> Round engine, starts one Round pass
//   round_done_i  : Round engine -> scheduler, the Round pass has finished
//   copy_start_o  : scheduler -> copy engine, starts one temp->buffer copy
//   copy_done_i   : copy engine -> scheduler, the copy has finished
//
// Modports:
//   master : scheduler side (drives the start pulses)
//   slave  : engine side (drives the done pulses)
// -----------------------------------------------------------------------------
interface gen_sched_ctrl_if;
    logic round_start_o;
    logic round_done_i;
    logic copy_start_o;
    logic copy_done_i;

    modport master (
        output round_start_o,
        output copy_start_o,
        input  round_done_i,
        input  copy_done_i
    );

    modport slave (
        input  round_start_o,
        input  copy_start_o,
        output round_done_i,
        output copy_done_i
    );
endinterface

// File: rtl/gen_sched_ctrl.sv
// -----------------------------------------------------------------------------
// gen_sched_ctrl
// Sequences one Game-of-Life generation:
//   1. COMPUTE  : the Round engine reads the engine-side buffer and writes temp.
//   2. COPY_A   : temp is copied into the engine-side buffer.
//   3. WAIT_VS  : wait for the start of vertical sync, so the swap is frame aligned.
//   4. SWAP     : buf_sel_o toggles and the generation counter increments.
//   5. COPY_B   : temp is copied into the new engine-side buffer (the stale one).
// After step 5 both buffers hold the new generation. buf_sel_o drives the RAM
// muxes in the top level. VGA always reads the buffer that buf_sel_o does not select.
//
// Ports:
//   clk          pixel/system clock (clk_vga domain)
//   rst_n        asynchronous reset, active low
//   tick_i       one-cycle evolution tick; acts as a trigger only while run_i = 1
//   run_i        level; 1 = free-run on ticks
//   step_i       one-cycle single-step request; acts as a trigger whatever run_i is
//   vsync_i      VGA vertical sync, synchronous to clk
//   eng          start/done handshake to the engines (master modport)
//   buf_sel_o    engine-side buffer index
//   busy_o       1 whenever the state is not IDLE
//   phase_o      current state encoding (IDLE=0 ... COPY_B=5)
//   gen_count_o  completed generations; wraps to 0 at 2^GEN_W
//   overrun_o    sticky; a trigger was dropped because one was already pending
//   error_o      sticky; an engine phase was aborted by the watchdog
//
// Optional build macro GEN_TIMEOUT_EN:
//   When it is defined, a watchdog limits COMPUTE, COPY_A and COPY_B to TIMEOUT_CYC
//   cycles each. On expiry the FSM returns to IDLE and sets error_o.
//   When it is undefined, no watchdog exists, error_o is 0 and the FSM waits
//   for the done pulses without a limit.
// -----------------------------------------------------------------------------
module gen_sched_ctrl #(
    parameter int GEN_W       = 16,
    parameter bit VS_ACTIVE   = 1'b1,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_i,
    input  logic                    run_i,
    input  logic                    step_i,
    input  logic                    vsync_i,
    gen_sched_ctrl_if.master        eng,
    output logic                    buf_sel_o,
    output logic                    busy_o,
    output logic [2:0]              phase_o,
    output logic [GEN_W-1:0]        gen_count_o,
    output logic                    overrun_o,
    output logic                    error_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        COPY_A  = 3'd2,
        WAIT_VS = 3'd3,
        SWAP    = 3'd4,
        COPY_B  = 3'd5
    } state_t;

    state_t state_reg;
    logic   pending_reg;
    logic   vs_prev_reg;
    logic   trig;
    logic   vs_act;
    logic   vs_rise;
    logic   abort;

    assign trig    = (tick_i & run_i) | step_i;
    assign vs_act  = (vsync_i == VS_ACTIVE);
    // The previous sample is updated in every state. An edge that has already
    // occurred when WAIT_VS is entered therefore shows as vs_prev_reg = 1 and
    // does not count.
    assign vs_rise = vs_act & ~vs_prev_reg;
    assign phase_o = state_reg;

`ifdef GEN_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_reg;
    logic            error_reg;
    logic            timed_state;
    logic            done_here;

    assign timed_state = (state_reg == COMPUTE) || (state_reg == COPY_A) ||
                         (state_reg == COPY_B);
    assign done_here   = ((state_reg == COMPUTE) && eng.round_done_i) ||
                         (((state_reg == COPY_A) || (state_reg == COPY_B)) && eng.copy_done_i);
    // A done pulse in the last allowed cycle still wins over the abort.
    assign abort       = timed_state && !done_here &&
                         (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
    assign error_o     = error_reg;

    // Counts the cycles spent in the current timed state. The counter is cleared
    // whenever the FSM leaves the state and whenever the FSM is in an untimed state.
    // Every entry into a timed state therefore starts with a count of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            if (timed_state && !done_here && !abort) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end else begin
                to_cnt_reg <= '0;
            end
            if (abort) begin
                error_reg <= 1'b1;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            pending_reg       <= 1'b0;
            vs_prev_reg       <= 1'b0;
            eng.round_start_o <= 1'b0;
            eng.copy_start_o  <= 1'b0;
            buf_sel_o         <= 1'b0;
            busy_o            <= 1'b0;
            gen_count_o       <= '0;
            overrun_o         <= 1'b0;
        end else begin
            // The start pulses are high only in the first cycle of their state.
            eng.round_start_o <= 1'b0;
            eng.copy_start_o  <= 1'b0;
            vs_prev_reg       <= vs_act;

            // While busy, a trigger is held in a one-deep queue. A second trigger
            // is dropped and sets the overrun flag.
            if ((state_reg != IDLE) && trig) begin
                if (pending_reg) begin
                    overrun_o <= 1'b1;
                end else begin
                    pending_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (trig || pending_reg) begin
                        state_reg         <= COMPUTE;
                        eng.round_start_o <= 1'b1;
                        busy_o            <= 1'b1;
                        // A new trigger and a pending trigger together: start
                        // with one of them and keep the other pending.
                        pending_reg       <= trig & pending_reg;
                    end
                end

                COMPUTE: begin
                    if (eng.round_done_i) begin
                        state_reg        <= COPY_A;
                        eng.copy_start_o <= 1'b1;
                    end else if (abort) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                    end
                end

                COPY_A: begin
                    if (eng.copy_done_i) begin
                        state_reg <= WAIT_VS;
                    end else if (abort) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                    end
                end

                WAIT_VS: begin
                    // The swap is applied on entry to SWAP, so the new buffer
                    // index and count are visible in the SWAP cycle itself.
                    if (vs_rise) begin
                        state_reg   <= SWAP;
                        buf_sel_o   <= ~buf_sel_o;
                        gen_count_o <= gen_count_o + GEN_W'(1);
                    end
                end

                SWAP: begin
                    state_reg        <= COPY_B;
                    eng.copy_start_o <= 1'b1;
                end

                COPY_B: begin
                    if (eng.copy_done_i) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                    end else if (abort) begin
                        state_reg <= IDLE;
                        busy_o    <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gen_sched_ctrl
// Self-checking bench for gen_sched_ctrl. It has four parts:
//   - a table of directed vectors for a full generation, for a single step, for
//     vsync already high on entry, and for done pulses that arrive in IDLE;
//   - hand-written sequences for the pending/overrun trigger, for an
//     asynchronous reset in the middle of a generation, and (when
//     GEN_TIMEOUT_EN is defined) for the watchdog;
//   - a randomized run.
// An abstract reference model follows the generation lifecycle. The bench
// compares the model with every DUT output after every clock.
// -----------------------------------------------------------------------------
module tb_gen_sched_ctrl;
    localparam int GW = 4;
    localparam int TO = 16;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick_i;
    logic          run_i;
    logic          step_i;
    logic          vsync_i;
    logic          buf_sel_o;
    logic          busy_o;
    logic [2:0]    phase_o;
    logic [GW-1:0] gen_count_o;
    logic          overrun_o;
    logic          error_o;

    gen_sched_ctrl_if eng_if ();

    gen_sched_ctrl #(
        .GEN_W      (GW),
        .VS_ACTIVE  (1'b1),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_i     (tick_i),
        .run_i      (run_i),
        .step_i     (step_i),
        .vsync_i    (vsync_i),
        .eng        (eng_if.master),
        .buf_sel_o  (buf_sel_o),
        .busy_o     (busy_o),
        .phase_o    (phase_o),
        .gen_count_o(gen_count_o),
        .overrun_o  (overrun_o),
        .error_o    (error_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc = 0;

    // ---------------- reference model ----------------
    // The model state is the lifecycle phase and the number of cycles spent in
    // it, a pending counter (0 or 1), and the sticky flags.
    int            m_ph;
    int            m_age;
    bit            m_pend;
    bit            m_ovr;
    bit            m_err;
    bit            m_sel;
    bit            m_busy;
    bit            m_rs;
    bit            m_cs;
    bit            m_vs_prev;
    logic [GW-1:0] m_gen;

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_pend = 0; m_ovr = 0; m_err = 0;
        m_sel = 0; m_busy = 0; m_rs = 0; m_cs = 0; m_vs_prev = 0; m_gen = '0;
    endtask

    task automatic model_next();
        bit trig;
        bit vs_on;
        bit rose;
        bit done;
        int nph;
        trig  = (tick_i && run_i) || step_i;
        vs_on = (vsync_i === 1'b1);
        rose  = vs_on && !m_vs_prev;
        done  = ((m_ph == 1) && (eng_if.round_done_i === 1'b1)) ||
                (((m_ph == 2) || (m_ph == 5)) && (eng_if.copy_done_i === 1'b1));
        nph   = m_ph;
        if (m_ph == 0) begin
            if (trig || m_pend) begin
                nph    = 1;
                m_pend = trig && m_pend;
            end
        end else begin
            if (trig) begin
                if (m_pend) m_ovr = 1'b1;
                else        m_pend = 1'b1;
            end
            if (done) begin
                nph = (m_ph == 1) ? 2 : ((m_ph == 2) ? 3 : 0);
            end else if ((m_ph == 3) && rose) begin
                nph   = 4;
                m_sel = !m_sel;
                m_gen = m_gen + GW'(1);
            end else if (m_ph == 4) begin
                nph = 5;
            end
`ifdef GEN_TIMEOUT_EN
            else if (((m_ph == 1) || (m_ph == 2) || (m_ph == 5)) && (m_age == TO - 1)) begin
                nph   = 0;
                m_err = 1'b1;
            end
`endif
        end
        m_rs      = (nph == 1) && (m_ph != 1);
        m_cs      = (nph != m_ph) && ((nph == 2) || (nph == 5));
        m_age     = (nph == m_ph) ? m_age + 1 : 0;
        m_ph      = nph;
        m_busy    = (nph != 0);
        m_vs_prev = vs_on;
    endtask

    // ---------------- checking helpers ----------------
    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, n_cyc);
        end
    endtask

    task automatic check_all(input string name);
        logic [12:0] dv;
        logic [12:0] mv;
        dv = {phase_o, eng_if.round_start_o, eng_if.copy_start_o, buf_sel_o,
              busy_o, overrun_o, error_o, gen_count_o};
        mv = {3'(m_ph), m_rs, m_cs, m_sel, m_busy, m_ovr, m_err, m_gen};
        cmp(name, int'(dv), int'(mv));
    endtask

    // Advance one clock: the model sees the inputs that the DUT samples on this
    // edge, and the outputs are compared 1 ns after the edge.
    task automatic step();
        if (!rst_n) model_reset();
        else        model_next();
        @(posedge clk);
        #1;
        n_cyc++;
        check_all("model");
    endtask

    task automatic clear_inputs();
        tick_i = 0; run_i = 0; step_i = 0; vsync_i = 0;
        eng_if.round_done_i = 0; eng_if.copy_done_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) step();
        rst_n = 1;
    endtask

    // Completes a generation that is in COMPUTE and returns the FSM to IDLE.
    task automatic finish_gen();
        eng_if.round_done_i = 1; step(); eng_if.round_done_i = 0;
        eng_if.copy_done_i  = 1; step(); eng_if.copy_done_i  = 0;
        vsync_i = 0; step();
        vsync_i = 1; step();
        step();
        eng_if.copy_done_i  = 1; step(); eng_if.copy_done_i  = 0;
        vsync_i = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int n;
        bit tick, run, stp, vs, rd, cd;
        int ph;
        bit rs, cs, sel, busy;
        int gen;
    } vec_t;

    vec_t tbl [NV];

    initial begin
        //          n  tk rn st vs rd cd  ph rs cs sel bsy gen
        tbl[0]  = '{1,  1, 1, 0, 0, 0, 0,  1, 1, 0, 0,  1,  0};
        tbl[1]  = '{99, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  1,  0};
        tbl[2]  = '{1,  0, 1, 0, 0, 1, 0,  2, 0, 1, 0,  1,  0};
        tbl[3]  = '{5,  0, 1, 0, 0, 0, 0,  2, 0, 0, 0,  1,  0};
        tbl[4]  = '{1,  0, 1, 0, 0, 0, 1,  3, 0, 0, 0,  1,  0};
        tbl[5]  = '{4,  0, 1, 0, 0, 0, 0,  3, 0, 0, 0,  1,  0};
        tbl[6]  = '{1,  0, 1, 0, 1, 0, 0,  4, 0, 0, 1,  1,  1};
        tbl[7]  = '{1,  0, 1, 0, 1, 0, 0,  5, 0, 1, 1,  1,  1};
        tbl[8]  = '{3,  0, 1, 0, 1, 0, 0,  5, 0, 0, 1,  1,  1};
        tbl[9]  = '{1,  0, 1, 0, 1, 0, 1,  0, 0, 0, 1,  0,  1};
        tbl[10] = '{3,  1, 0, 0, 1, 0, 0,  0, 0, 0, 1,  0,  1};
        tbl[11] = '{1,  0, 0, 1, 1, 0, 0,  1, 1, 0, 1,  1,  1};
        tbl[12] = '{1,  0, 0, 0, 1, 1, 0,  2, 0, 1, 1,  1,  1};
        tbl[13] = '{1,  0, 0, 0, 1, 0, 1,  3, 0, 0, 1,  1,  1};
        tbl[14] = '{5,  0, 0, 0, 1, 0, 0,  3, 0, 0, 1,  1,  1};
        tbl[15] = '{2,  0, 0, 0, 0, 0, 0,  3, 0, 0, 1,  1,  1};
        tbl[16] = '{1,  0, 0, 0, 1, 0, 0,  4, 0, 0, 0,  1,  2};
        tbl[17] = '{1,  0, 0, 0, 1, 0, 0,  5, 0, 1, 0,  1,  2};
        tbl[18] = '{1,  0, 0, 0, 1, 0, 1,  0, 0, 0, 0,  0,  2};
        tbl[19] = '{1,  0, 0, 0, 1, 1, 1,  0, 0, 0, 0,  0,  2};

        // Reset state, which the model compares inside do_reset.
        do_reset();

        for (int i = 0; i < NV; i++) begin
            tick_i = tbl[i].tick; run_i = tbl[i].run; step_i = tbl[i].stp;
            vsync_i = tbl[i].vs;
            eng_if.round_done_i = tbl[i].rd; eng_if.copy_done_i = tbl[i].cd;
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                cmp($sformatf("vec%0d", i),
                    int'({phase_o, eng_if.round_start_o, eng_if.copy_start_o, buf_sel_o, busy_o, gen_count_o}),
                    int'({3'(tbl[i].ph), tbl[i].rs, tbl[i].cs, tbl[i].sel, tbl[i].busy, GW'(tbl[i].gen)}));
            end
            $display("vec %0d: n=%0d phase=%0d sel=%0d gen=%0d", i, tbl[i].n, phase_o, buf_sel_o, gen_count_o);
        end
        clear_inputs();

        // Two more triggers during COMPUTE: the first is held pending, the second overruns.
        do_reset();
        run_i = 1; tick_i = 1;
        step(); step(); step();
        tick_i = 0; run_i = 0;
        cmp("overrun_set", int'(overrun_o), 1);
        finish_gen();
        cmp("idle_between", int'(phase_o), 0);
        step();
        cmp("auto_start_phase", int'(phase_o), 1);
        cmp("auto_start_pulse", int'(eng_if.round_start_o), 1);
        finish_gen();
        repeat (4) step();
        cmp("two_gens_phase", int'(phase_o), 0);
        cmp("two_gens_count", int'(gen_count_o), 2);
        $display("overrun seq: gen=%0d overrun=%0d", gen_count_o, overrun_o);

        // Asynchronous reset in COPY_A, with buf_sel_o = 1 before the reset.
        do_reset();
        step_i = 1; step(); step_i = 0;
        finish_gen();
        cmp("pre_rst_sel", int'(buf_sel_o), 1);
        step_i = 1; step(); step_i = 0;
        eng_if.round_done_i = 1; step(); eng_if.round_done_i = 0;
        cmp("pre_rst_phase", int'(phase_o), 2);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        check_all("async_rst");
        cmp("async_rst_sel", int'(buf_sel_o), 0);
        step(); step();
        rst_n = 1;
        eng_if.round_done_i = 1; step(); eng_if.round_done_i = 0;
        eng_if.copy_done_i  = 1; step(); eng_if.copy_done_i  = 0;
        cmp("done_ignored_phase", int'(phase_o), 0);
        cmp("done_ignored_busy", int'(busy_o), 0);
        $display("async reset seq: phase=%0d sel=%0d", phase_o, buf_sel_o);

`ifdef GEN_TIMEOUT_EN
        // Watchdog: round_done_i is withheld for the whole COMPUTE limit.
        do_reset();
        step_i = 1; step(); step_i = 0;
        repeat (TO - 1) step();
        cmp("to_still_compute", int'(phase_o), 1);
        step();
        cmp("to_idle", int'(phase_o), 0);
        cmp("to_error", int'(error_o), 1);
        cmp("to_gen", int'(gen_count_o), 0);
        cmp("to_sel", int'(buf_sel_o), 0);
        $display("timeout seq: phase=%0d error=%0d", phase_o, error_o);
`endif

        // Randomized run, compared cycle by cycle with the model.
        do_reset();
        run_i = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) run_i = !run_i;
            tick_i              = ($urandom_range(0, 7) == 0);
            step_i              = ($urandom_range(0, 39) == 0);
            eng_if.round_done_i = ($urandom_range(0, 5) == 0);
            eng_if.copy_done_i  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) vsync_i = !vsync_i;
            step();
        end
        $display("random run: gen=%0d sel=%0d overrun=%0d", gen_count_o, buf_sel_o, overrun_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gen_sched_ctrl.md
Name: gen_sched_ctrl

Overview:
- Sequences one Game-of-Life generation: compute (Round engine reads the engine-side buffer and writes the temp RAM), then copy temp into the engine-side buffer, then a frame-aligned ping-pong swap, then a second copy so both buffers hold the new generation.
- Owns `buf_sel_o`, which drives the RAM address/enable/data muxes in the top level in place of a free-running toggle.
- Sits between the evolution tick generator, user run/step controls, the Round/copy engines and the VGA timing.

Parameters:
- GEN_W, 16, width of the generation counter.
- VS_ACTIVE, 1, active level of `vsync_i`; 1 matches the 800x600 timing, whose sync polarity is 1.
- TIMEOUT_CYC, 1048576, watchdog limit in clk cycles per engine phase; used only with GEN_TIMEOUT_EN.

Ports:
- clk, input, 1, pixel/system clock (clk_vga domain).
- rst_n, input, 1, asynchronous active-low reset.
- tick_i, input, 1, one-cycle evolution tick pulse.
- run_i, input, 1, level; 1 = free-run on ticks.
- step_i, input, 1, one-cycle single-step request; honoured regardless of run_i.
- vsync_i, input, 1, VGA vertical sync, synchronous to clk.
- round_start_o, output, 1, one-cycle pulse that starts a Round pass.
- round_done_i, input, 1, one-cycle pulse at the end of a Round pass.
- copy_start_o, output, 1, one-cycle pulse that starts a temp->buffer copy.
- copy_done_i, input, 1, one-cycle pulse at the end of a copy.
- buf_sel_o, output, 1, engine-side buffer index; VGA reads the other buffer.
- busy_o, output, 1, 1 whenever state != IDLE.
- phase_o, output, 3, current state encoding.
- gen_count_o, output, GEN_W, completed generations.
- overrun_o, output, 1, sticky flag: a trigger was dropped.
- error_o, output, 1, sticky watchdog abort flag.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state = IDLE; pending = 0; vsync edge register = 0.
- Trigger definition:
  - trig = (tick_i & run_i) | step_i.
- Trigger handling:
  - A one-deep pending flag captures a trigger while busy.
  - A trigger arriving while pending is already 1 is dropped and sets overrun_o.
  - overrun_o clears only on reset.
- States (phase_o encoding):
  - IDLE (0): if trig or pending, go to COMPUTE next cycle and clear pending. A trig and pending in the same cycle consume one and keep pending = 1.
  - COMPUTE (1): round_start_o = 1 on the first cycle of the state only. On round_done_i go to COPY_A.
  - COPY_A (2): copy_start_o pulses on the entry cycle. On copy_done_i go to WAIT_VS.
  - WAIT_VS (3): wait for the rising edge of vsync into its active level (VS_ACTIVE), detected with a registered previous value. An edge already in progress when the state is entered does not count. Then go to SWAP.
  - SWAP (4): exactly one cycle. buf_sel_o toggles and gen_count_o increments (wraps at 2^GEN_W to 0). Go to COPY_B.
  - COPY_B (5): copy_start_o pulses on the entry cycle. Copy targets the new engine-side buffer, which is the stale one. On copy_done_i go to IDLE.
- Latency:
  - trig in IDLE at cycle t gives round_start_o at t+1.
  - round_done_i at cycle t gives copy_start_o at t+1.
- Done inputs:
  - A done pulse is accepted in any cycle of its own state, including the start cycle.
  - round_done_i outside COMPUTE and copy_done_i outside COPY_A/COPY_B are ignored.
- Buffer ownership:
  - buf_sel_o changes only in SWAP, so VGA never sees a partial frame.
  - Between swaps, buffers are never written on the VGA side.
- Simultaneous events: a trigger arriving in the same cycle as SWAP or a done pulse sets pending and does not disturb the sequence.
- Reset mid-operation: returns to IDLE at once with buf_sel_o = 0. Buffer contents are undefined; the bench must reload them.

Optional Feature:
- Macro: GEN_TIMEOUT_EN.
- When defined:
  - A counter runs in COMPUTE, COPY_A and COPY_B and resets on every state entry. WAIT_VS is excluded.
  - If the counter reaches TIMEOUT_CYC with no done pulse, go to IDLE, set error_o (sticky), and leave buf_sel_o and gen_count_o unchanged.
  - pending is preserved across the abort.
- When undefined: no counter exists, error_o is tied to 0, and the block waits indefinitely for done pulses.

Test Plan:
- Reset, then run_i=1 with one tick_i → round_start_o at +1 cycle; round_done_i 100 cycles later → copy_start_o +1; copy_done_i → phase_o=3 until vsync rises → SWAP: buf_sel_o=1, gen_count_o=1 → second copy_start_o → IDLE with busy_o=0.
- run_i=0, tick_i pulses → no start; step_i pulse → one full generation, gen_count_o=1.
- Two ticks during COMPUTE → pending=1, overrun_o=1; the next generation starts automatically at the IDLE entry, and exactly 2 generations complete in total.
- vsync_i already high on entry to WAIT_VS → no swap until low→high; buf_sel_o toggles exactly on that edge.
- rst_n low during COPY_A → all outputs 0 immediately (asynchronous); later round_done_i and copy_done_i pulses are ignored in IDLE.
- With GEN_TIMEOUT_EN and TIMEOUT_CYC=16, withhold round_done_i → IDLE after 16 cycles, error_o=1, gen_count_o unchanged, buf_sel_o unchanged.
